uart_rx_frame_ctrl: RTL and testbench
=====================================

Name: uart_rx_frame_ctrl

Overview:
UART receive frame controller for the RX path.
- Detects the start edge on RX_IN and generates the oversampling edge count and sample enable consumed by the data_sampling stage.
- Consumes that stage's sampled_bit, walks the frame start -> 8 data -> optional parity -> stop, and assembles the byte.
- Reports data_valid / par_err / stp_err to the RX-to-system-bus side.
- Contains the edge/bit counting, the RX FSM and the deserializer in one block.

Parameters:
DATA_WIDTH, 8, data bits per frame, sent LSB first.
EDGE_W, 5, width of edge_cnt; supports Prescale up to 32.

Ports:
CLK  in  1  RX oversampling clock.
RST  in  1  reset, synchronous, active-low.
RX_IN  in  1  serial line, idle high.
Prescale  in  6  oversampling ratio; legal values 8, 16, 32.
PAR_EN  in  1  1 = parity bit present.
PAR_TYP  in  1  0 = even, 1 = odd.
sampled_bit  in  1  majority-voted bit from data_sampling; updated on the edge where edge_cnt == Prescale/2+1.
dat_samp_en  out  1  sample enable to data_sampling.
edge_cnt  out  EDGE_W  oversampling edge index within the current bit, 0..Prescale-1.
P_DATA  out  DATA_WIDTH  received byte; holds its value until the next frame completes.
data_valid  out  1  one-cycle pulse, byte good.
par_err  out  1  one-cycle pulse, parity mismatch.
stp_err  out  1  one-cycle pulse, stop bit sampled 0.

Behaviour:
- Reset (RST=0 at a CLK edge, including mid-frame):
  - State IDLE; edge_cnt, bit counter, P_DATA, data_valid, par_err, stp_err, dat_samp_en all 0.
  - Any frame in progress is abandoned; no pulse is issued for it.
- States: IDLE, START, DATA, PARITY, STOP. dat_samp_en = 1 in every state except IDLE.
- Configuration latch: Prescale, PAR_EN and PAR_TYP are captured on start detection and used for the whole frame. Changes mid-frame have no effect.
- IDLE:
  - edge_cnt held at 0.
  - When RX_IN = 0 at a CLK edge, that edge counts as edge 0 of the start bit: state <= START, edge_cnt <= 1.
- Edge counting:
  - Outside IDLE, edge_cnt increments every cycle.
  - At Prescale-1 it wraps to 0 and the bit is "closed".
- Bit decisions:
  - All decisions use sampled_bit on the cycle where edge_cnt == Prescale-1.
  - sampled_bit is stable there for every legal Prescale, since Prescale/2+2 <= Prescale-1.
- START close:
  - sampled_bit = 1: glitch, go to IDLE with no flags.
  - sampled_bit = 0: go to DATA, bit counter = 0.
- DATA close:
  - P_DATA shadow register shifts right with sampled_bit entering the MSB, giving LSB-first reception.
  - After bit DATA_WIDTH-1: go to PARITY if PAR_EN, else STOP.
- PARITY close:
  - Expected bit = XOR of the 8 data bits XOR PAR_TYP.
  - On mismatch, par_err = 1 for the next cycle. The frame is marked bad and the state still goes to STOP.
- STOP close:
  - sampled_bit = 0: stp_err = 1 for the next cycle.
  - Frame good (no parity or stop error): P_DATA is updated from the shadow register and data_valid = 1 in the same next cycle. Otherwise P_DATA keeps its previous value.
  - Next state is IDLE. If RX_IN = 0 on that same edge, go straight to START with edge_cnt <= 1, so back-to-back frames lose no cycle.
- Simultaneous parity and stop errors: par_err pulses at the parity close and stp_err at the stop close. data_valid is not asserted.
- Illegal Prescale (not 8/16/32): behaviour unspecified; the bench does not exercise it.

Decomposition:
- Shared uart package holds:
  - state encoding (3-bit localparams for IDLE..STOP);
  - PAR_EVEN = 0, PAR_ODD = 1;
  - legal prescale constants 8/16/32.
- Natural sub-module: uart_rx_edge_bit_counter.
  - Holds edge_cnt, the bit counter and the wrap/close flags, enabled by the FSM.
  - FSM, parity check and deserializer stay in the top.

Test Plan:
- Prescale = 8, PAR_EN = 0, send 0xA5 with stop 1 -> data_valid pulse, P_DATA = 0xA5, par_err = stp_err = 0.
- Prescale = 16, PAR_EN = 1, PAR_TYP = 0, send 0x3C with parity bit 0 -> data_valid, P_DATA = 0x3C. Resend with parity bit 1 -> par_err pulse, no data_valid, P_DATA stays 0x3C.
- Prescale = 32, PAR_EN = 1, PAR_TYP = 1, send 0x00 with parity 1 and stop 0 -> stp_err pulse only, no data_valid.
- RX_IN low for 2 cycles then high (Prescale = 8) -> START close sees sampled_bit = 1, return to IDLE, no flags, dat_samp_en deasserts.
- Two back-to-back frames 0x55 then 0xF0 (Prescale = 8, no idle gap) -> two data_valid pulses 80 cycles apart, P_DATA = 0x55 then 0xF0.
- Assert RST = 0 during DATA bit 4 -> next cycle all outputs 0, state IDLE. The following full frame 0x81 is received correctly.

Source files
------------

// File: rtl/uart_rx_frame_ctrl_pkg.sv
// Shared constants for the UART receive path: FSM state encoding,
// parity-type codes and the supported oversampling ratios.
package uart_rx_frame_ctrl_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int PRESCALE_8  = 8;
  localparam int PRESCALE_16 = 16;
  localparam int PRESCALE_32 = 32;

  function automatic logic legal_prescale(input logic [5:0] p);
    return (int'(p) == PRESCALE_8) || (int'(p) == PRESCALE_16) || (int'(p) == PRESCALE_32);
  endfunction

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// Oversampling edge counter and data-bit counter for the UART RX frame
// controller; raises bit_close on the last edge of every bit period.
module uart_rx_edge_bit_counter #(
  parameter int DATA_WIDTH = 8,
  parameter int EDGE_W     = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              en,
  input  logic              load,
  input  logic [EDGE_W:0]   prescale,
  input  logic              bit_clr,
  input  logic              bit_inc,
  output logic [EDGE_W-1:0] edge_cnt,
  output logic              bit_close,
  output logic              bit_last
);

  localparam int BIT_W = $clog2(DATA_WIDTH);
  localparam logic [EDGE_W:0] PRE_ONE = 1;

  logic [BIT_W-1:0] bit_cnt;

  assign bit_close = en && ({1'b0, edge_cnt} == (prescale - PRE_ONE));
  assign bit_last  = (bit_cnt == BIT_W'(DATA_WIDTH - 1));

  // load wins over the wrap so a start on the stop-close edge begins at edge 1
  always_ff @(posedge CLK) begin
    if (!RST)
      edge_cnt <= '0;
    else if (load)
      edge_cnt <= EDGE_W'(1);
    else if (!en || bit_close)
      edge_cnt <= '0;
    else
      edge_cnt <= edge_cnt + EDGE_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (!RST)
      bit_cnt <= '0;
    else if (bit_clr)
      bit_cnt <= '0;
    else if (bit_inc)
      bit_cnt <= bit_cnt + BIT_W'(1);
  end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART RX frame controller: start detection, frame FSM, parity/stop
// checking and LSB-first deserialization with per-frame configuration.
module uart_rx_frame_ctrl
  import uart_rx_frame_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int EDGE_W     = 5
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [EDGE_W:0]       Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  sampled_bit,
  output logic                  dat_samp_en,
  output logic [EDGE_W-1:0]     edge_cnt,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  logic [2:0]            state, next_state;
  logic [EDGE_W:0]       pre_q;
  logic                  par_en_q, par_typ_q;
  logic [DATA_WIDTH-1:0] shadow;
  logic                  bad_q;
  logic                  bit_close, bit_last;
  logic                  start_det;
  logic                  par_mismatch;

  assign start_det = !RX_IN && ((state == ST_IDLE) || (state == ST_STOP && bit_close));
  assign par_mismatch = ((^shadow) ^ (par_typ_q == PAR_ODD)) != sampled_bit;

  uart_rx_edge_bit_counter #(
    .DATA_WIDTH (DATA_WIDTH),
    .EDGE_W     (EDGE_W)
  ) u_cnt (
    .CLK       (CLK),
    .RST       (RST),
    .en        (dat_samp_en),
    .load      (start_det),
    .prescale  (pre_q),
    .bit_clr   (state == ST_START && bit_close),
    .bit_inc   (state == ST_DATA && bit_close),
    .edge_cnt  (edge_cnt),
    .bit_close (bit_close),
    .bit_last  (bit_last)
  );

  always_ff @(posedge CLK) begin
    if (!RST)
      state <= ST_IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (!RX_IN) next_state = ST_START;
      ST_START:  if (bit_close) next_state = sampled_bit ? ST_IDLE : ST_DATA;
      ST_DATA:   if (bit_close && bit_last) next_state = par_en_q ? ST_PARITY : ST_STOP;
      ST_PARITY: if (bit_close) next_state = ST_STOP;
      ST_STOP:   if (bit_close) next_state = RX_IN ? ST_IDLE : ST_START;
      default:   next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    dat_samp_en = (state != ST_IDLE);
  end

  // frame configuration and shift register carry no reset; they are
  // always written before being consumed
  always_ff @(posedge CLK) begin
    if (start_det) begin
      pre_q     <= Prescale;
      par_en_q  <= PAR_EN;
      par_typ_q <= PAR_TYP;
    end
    if (state == ST_DATA && bit_close)
      shadow <= {sampled_bit, shadow[DATA_WIDTH-1:1]};
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      P_DATA     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      bad_q      <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      if (start_det)
        bad_q <= 1'b0;
      if (state == ST_PARITY && bit_close && par_mismatch) begin
        par_err <= 1'b1;
        bad_q   <= 1'b1;
      end
      if (state == ST_STOP && bit_close) begin
        if (!sampled_bit)
          stp_err <= 1'b1;
        else if (!bad_q) begin
          P_DATA     <= shadow;
          data_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Scoreboard bench for uart_rx_frame_ctrl: directed frames are queued with
// their expected pulse, a negedge monitor pops and compares each pulse.
module tb_uart_rx_frame_ctrl;
  import uart_rx_frame_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_in;
  logic [5:0] prescale;
  logic       par_en, par_typ;
  logic       sampled_bit;
  logic       dat_samp_en;
  logic [4:0] edge_cnt;
  logic [7:0] p_data;
  logic       data_valid, par_err, stp_err;

  typedef struct {
    string      name;
    logic       dv;
    logic       pe;
    logic       se;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   cycle = 0;
  int   cur_pre = 8;
  int   last_dv_cycle = 0;
  int   prev_dv_cycle = 0;

  always #5 clk = ~clk;

  uart_rx_frame_ctrl dut (
    .CLK         (clk),
    .RST         (rst_n),
    .RX_IN       (rx_in),
    .Prescale    (prescale),
    .PAR_EN      (par_en),
    .PAR_TYP     (par_typ),
    .sampled_bit (sampled_bit),
    .dat_samp_en (dat_samp_en),
    .edge_cnt    (edge_cnt),
    .P_DATA      (p_data),
    .data_valid  (data_valid),
    .par_err     (par_err),
    .stp_err     (stp_err)
  );

  always @(posedge clk) cycle <= cycle + 1;

  // stand-in for data_sampling: capture the line mid-bit
  always @(posedge clk) begin
    if (!rst_n)
      sampled_bit <= 1'b1;
    else if (dat_samp_en && int'(edge_cnt) == cur_pre / 2 + 1)
      sampled_bit <= rx_in;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && (data_valid || par_err || stp_err)) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_pulse: got dv=%b pe=%b se=%b P_DATA=0x%h, required no pulse",
                 data_valid, par_err, stp_err, p_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check(e.name, {21'd0, data_valid, par_err, stp_err, p_data},
              {21'd0, e.dv, e.pe, e.se, e.data});
      end
      if (data_valid) begin
        prev_dv_cycle = last_dv_cycle;
        last_dv_cycle = cycle;
      end
    end
  end

  task automatic expect_pulse(input string name, input logic dv, input logic pe,
                              input logic se, input logic [7:0] d);
    exp_t e;
    e.name = name; e.dv = dv; e.pe = pe; e.se = se; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // nbits = 0 sends the whole frame, otherwise only the first nbits bit periods
  task automatic send_frame(input logic [7:0] d, input logic par_on, input logic par_bit,
                            input logic stop_bit, input int pre, input int nbits);
    logic [10:0] bits;
    int          total;
    int          n;
    bits      = '0;
    bits[8:1] = d;
    total     = 10;
    if (par_on) begin
      bits[9] = par_bit;
      total   = 11;
    end
    bits[total-1] = stop_bit;
    n        = (nbits > 0) ? nbits : total;
    prescale = 6'(pre);
    par_en   = par_on;
    cur_pre  = pre;
    for (int i = 0; i < n; i++) begin
      rx_in = bits[i];
      for (int k = 0; k < pre; k++) begin
        @(posedge clk);
        #1;
        if (i == 0 && k == 0)
          check("start_edge_cnt", {26'd0, dat_samp_en, edge_cnt}, {26'd0, 1'b1, 5'd1});
      end
    end
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    wait_cycles(n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    rx_in    = 1'b1;
    prescale = 6'd8;
    par_en   = 1'b0;
    par_typ  = PAR_EVEN;
    wait_cycles(3);
    check("reset_state", {18'd0, data_valid, par_err, stp_err, dat_samp_en, edge_cnt, p_data}, 32'd0);
    rst_n = 1'b1;
    idle(4);

    expect_pulse("frame_a5", 1'b1, 1'b0, 1'b0, 8'hA5);
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, PRESCALE_8, 0);
    idle(3 * PRESCALE_8);

    par_typ = PAR_EVEN;
    expect_pulse("frame_3c_even", 1'b1, 1'b0, 1'b0, 8'h3C);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, PRESCALE_16, 0);
    idle(3 * PRESCALE_16);
    expect_pulse("frame_3c_parerr", 1'b0, 1'b1, 1'b0, 8'h3C);
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1, PRESCALE_16, 0);
    idle(3 * PRESCALE_16);

    par_typ = PAR_ODD;
    expect_pulse("frame_00_stperr", 1'b0, 1'b0, 1'b1, 8'h3C);
    send_frame(8'h00, 1'b1, 1'b1, 1'b0, PRESCALE_32, 0);
    idle(3 * PRESCALE_32);

    prescale = 6'd8;
    par_en   = 1'b0;
    cur_pre  = PRESCALE_8;
    rx_in    = 1'b0;
    wait_cycles(2);
    check("glitch_samp_en_on", {31'd0, dat_samp_en}, 32'd1);
    rx_in = 1'b1;
    wait_cycles(8);
    check("glitch_back_idle", {26'd0, dat_samp_en, edge_cnt}, 32'd0);
    idle(2 * PRESCALE_8);

    expect_pulse("b2b_55", 1'b1, 1'b0, 1'b0, 8'h55);
    expect_pulse("b2b_f0", 1'b1, 1'b0, 1'b0, 8'hF0);
    send_frame(8'h55, 1'b0, 1'b0, 1'b1, PRESCALE_8, 0);
    send_frame(8'hF0, 1'b0, 1'b0, 1'b1, PRESCALE_8, 0);
    idle(3 * PRESCALE_8);
    check("b2b_gap", last_dv_cycle - prev_dv_cycle, 32'd80);

    send_frame(8'h96, 1'b0, 1'b0, 1'b1, PRESCALE_8, 5);
    rx_in = 1'b1;
    wait_cycles(3);
    rst_n = 1'b0;
    wait_cycles(1);
    check("midframe_reset", {18'd0, data_valid, par_err, stp_err, dat_samp_en, edge_cnt, p_data}, 32'd0);
    rst_n = 1'b1;
    idle(3 * PRESCALE_8);
    check("post_reset_pdata", {24'd0, p_data}, 32'd0);

    expect_pulse("frame_81", 1'b1, 1'b0, 1'b0, 8'h81);
    send_frame(8'h81, 1'b0, 1'b0, 1'b1, PRESCALE_8, 0);
    idle(3 * PRESCALE_8);

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
